// File: rtl/bcd_scan_display.sv
// Binary-to-BCD display driver: sequential double-dabble conversion into a
// latched display register, time-multiplexed onto active-low anodes/segments.
module bcd_scan_display #(
    parameter int unsigned WIDTH       = 14,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  bin,
    input  logic              load,
    input  logic              blank_lz,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam int unsigned SW = 4 * DIGITS + 4;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    shift_q, shift_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [SW-1:0]       adj;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic                ovf_q, ovf_d;
    logic [RW-1:0]       ref_q, ref_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic [3:0]          cur;
    logic                hi_zero;

    // Conversion FSM; overflow is decided on the captured input, not the guard nibble.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        adj        = scratch_q;
        for (int unsigned i = 0; i <= DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d    = bin;
                    scratch_d  = '0;
                    cnt_d      = CW'(WIDTH);
                    ovf_pend_d = (64'(bin) >= LIMIT);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = COMMIT;
            end
            COMMIT: begin
                disp_d  = scratch_q[4*DIGITS-1:0];
                ovf_d   = ovf_pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ref_d = (ref_q == RW'(REFRESH_DIV - 1)) ? '0 : ref_q + RW'(1);
        idx_d = idx_q;
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        cur     = '0;
        hi_zero = 1'b1;
        an_d    = '1;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            if (IW'(j) == idx_q) begin
                cur     = disp_q[4*j +: 4];
                an_d[j] = 1'b0;
            end
            if (IW'(j) >= idx_q && disp_q[4*j +: 4] != 4'd0) hi_zero = 1'b0;
        end
        if (ovf_q) begin
            seg_d = 7'h3F;
        end else if (blank_lz && idx_q != '0 && hi_zero) begin
            seg_d = 7'h7F;
        end else begin
            seg_d = decode(cur);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            ref_q      <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= '1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign ovf  = ovf_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: 14-bit/4-digit and 20-bit/6-digit instances.
module tb_bcd_scan_display;

    localparam int unsigned RD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        blank_lz = 1'b0;
    logic [13:0] bin_a = '0;
    logic [19:0] bin_b = '0;
    logic        load_a = 1'b0, load_b = 1'b0;
    logic        busy_a, busy_b, ovf_a, ovf_b;
    logic [3:0]  an_a;
    logic [5:0]  an_b;
    logic [6:0]  seg_a, seg_b;

    logic        sel = 1'b0;
    logic [5:0]  an_m;
    logic [6:0]  seg_m;
    logic        busy_m, ovf_m;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    typedef struct {
        int unsigned dig;
        logic [6:0]  seg;
        logic        ovf;
    } exp_t;
    exp_t sb[$];

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    bcd_scan_display #(.WIDTH(14), .DIGITS(4), .REFRESH_DIV(RD)) u_a (
        .clk(clk), .reset(reset), .bin(bin_a), .load(load_a), .blank_lz(blank_lz),
        .busy(busy_a), .ovf(ovf_a), .an(an_a), .seg(seg_a));

    bcd_scan_display #(.WIDTH(20), .DIGITS(6), .REFRESH_DIV(RD)) u_b (
        .clk(clk), .reset(reset), .bin(bin_b), .load(load_b), .blank_lz(blank_lz),
        .busy(busy_b), .ovf(ovf_b), .an(an_b), .seg(seg_b));

    always_comb begin
        an_m   = sel ? an_b   : {2'b11, an_a};
        seg_m  = sel ? seg_b  : seg_a;
        busy_m = sel ? busy_b : busy_a;
        ovf_m  = sel ? ovf_b  : ovf_a;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int unsigned p10(input int unsigned n);
        int unsigned p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(input int unsigned v, input int unsigned i,
                                           input int unsigned nd, input logic blk);
        if (v >= p10(nd)) return 7'h3F;
        if (blk && i > 0 && v < p10(i)) return 7'h7F;
        return seg_tab[(v / p10(i)) % 10];
    endfunction

    task automatic push_exp(input int unsigned v, input int unsigned nd, input logic blk);
        exp_t e;
        for (int unsigned i = 0; i < nd; i++) begin
            e.dig = i;
            e.seg = exp_seg(v, i, nd, blk);
            e.ovf = (v >= p10(nd));
            sb.push_back(e);
        end
    endtask

    task automatic drive_load(input int unsigned v);
        if (sel) begin bin_b = 20'(v); load_b = 1'b1; end
        else     begin bin_a = 14'(v); load_a = 1'b1; end
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned w = 0;
        while (busy_m && w < 100) begin @(negedge clk); w++; end
        if (w >= 100) check_val("idle_timeout", 32'(w), 32'd0);
    endtask

    task automatic check_scan(input int unsigned nd);
        exp_t        e;
        logic [5:0]  pat;
        int unsigned w, h;
        @(negedge clk);
        for (int unsigned k = 0; k < nd; k++) begin
            pat = 6'h3F & ~(6'd1 << k);
            w = 0;
            while (an_m !== pat && w < 64) begin @(negedge clk); w++; end
            if (w >= 64) check_val($sformatf("scan_wait_d%0d", k), 32'(an_m), 32'(pat));
            e = sb.pop_front();
            check_val($sformatf("seg_d%0d", e.dig), 32'(seg_m), 32'(e.seg));
            check_val($sformatf("ovf_d%0d", e.dig), 32'(ovf_m), 32'(e.ovf));
            h = 0;
            while (an_m === pat && h < 64) begin @(negedge clk); h++; end
            if (k > 0) check_val($sformatf("hold_d%0d", k), h, RD);
        end
    endtask

    task automatic load_val(input int unsigned v, input logic blk);
        int unsigned nd = sel ? 6 : 4;
        int unsigned wd = sel ? 20 : 14;
        int unsigned n  = 0;
        wait_idle();
        blank_lz = blk;
        drive_load(v);
        while (busy_m && n < 100) begin @(negedge clk); n++; end
        check_val($sformatf("busy_len_%0d", v), n, wd + 1);
        push_exp(v, nd, blk);
        check_scan(nd);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_val("rst_an", 32'(an_m), 32'h3F);
        check_val("rst_seg", 32'(seg_m), 32'h7F);
        check_val("rst_busy", 32'(busy_m), 32'd0);
        check_val("rst_ovf", 32'(ovf_m), 32'd0);
        reset = 1'b0;
        push_exp(0, 4, 1'b0);
        check_scan(4);

        load_val(1234, 1'b0);
        load_val(9999, 1'b0);
        load_val(10000, 1'b0);
        load_val(7, 1'b1);
        load_val(0, 1'b1);
        load_val(1005, 1'b1);

        // load during busy is dropped
        blank_lz = 1'b0;
        drive_load(42);
        @(negedge clk);
        drive_load(99);
        wait_idle();
        push_exp(42, 4, 1'b0);
        check_scan(4);

        // reset mid-conversion must not commit
        drive_load(5555);
        repeat (7) @(negedge clk);
        check_val("abort_busy_pre", 32'(busy_m), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("abort_busy", 32'(busy_m), 32'd0);
        check_val("abort_ovf", 32'(ovf_m), 32'd0);
        push_exp(0, 4, 1'b0);
        check_scan(4);
        repeat (20) @(negedge clk);
        check_val("abort_still_idle", 32'(busy_m), 32'd0);

        sel = 1'b1;
        load_val(999999, 1'b0);
        load_val(1000000, 1'b0);
        load_val(305, 1'b1);

        check_val("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Parametrised successor to the fixed 4-digit timer display path.
- Takes a WIDTH-bit binary value on a load strobe and converts it to DIGITS BCD digits with a sequential double-dabble engine.
- Latches the result and time-multiplexes it onto active-low anode and segment outputs.
- Adds leading-zero blanking, overflow indication (dashes) and a busy handshake. It sits between the game timer/counter logic and the board's seven-segment pins.

Parameters:
- WIDTH, 14, bit width of the binary input.
- DIGITS, 4, number of display digits / anodes.
- REFRESH_DIV, 100000, clk cycles each digit stays lit (1 ms at 100 MHz); minimum 1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- bin  input  WIDTH  unsigned value to display, sampled on the load cycle.
- load  input  1  start conversion; one-cycle pulse or level.
- blank_lz  input  1  1 = blank leading zeros; sampled combinationally during scan.
- busy  output  1  conversion in progress; load ignored while high.
- ovf  output  1  last committed value was >= 10^DIGITS.
- an  output  DIGITS  anode enables, active low, an[0] = ones digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - FSM to IDLE; busy=0; ovf=0.
  - Display register all-zero digits; digit index 0; refresh counter 0.
  - an and seg are registered; they read all-ones on the first edge after reset.
  - Reset has priority over load and aborts any conversion in progress without committing.
- FSM states IDLE, SHIFT, COMMIT:
  - IDLE: on load=1, capture bin into the shift register, clear the BCD scratch (4*DIGITS bits plus 4 guard bits), set the bit counter to WIDTH, go to SHIFT. busy=1 from the next cycle.
  - SHIFT (WIDTH cycles): each cycle, every scratch nibble >= 5 gets +3, then {scratch, shift} shifts left 1. Decrement the counter; after the WIDTH-th shift go to COMMIT.
  - COMMIT (1 cycle):
    - Display register <= low DIGITS nibbles of scratch.
    - ovf <= (captured value >= 10^DIGITS), computed as a compare on the captured input, not from the guard bits.
    - busy deasserts on the following edge; return to IDLE.
- Latency and load rules:
  - load at edge 0 means busy is high on cycles 1..WIDTH+1 and the new digits are visible from edge WIDTH+2.
  - load while busy=1 is ignored and not queued.
  - load held high re-triggers on the first IDLE cycle.
- The old value keeps displaying throughout a conversion; there is no flicker or intermediate digits.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, the digit index advances modulo DIGITS (DIGITS-1 -> 0).
  - an = all ones except bit[index] = 0.
- Segment data for the current index:
  - If ovf=1: dash, 7'h3F, on every digit; blanking is ignored.
  - Else if blank_lz=1, index>0, and digit[index] and all higher digits are 0: 7'h7F (blank). Digit 0 is never blanked.
  - Else decode: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Any nibble >9 (unreachable) gives 7'h7F.
- an and seg update on the same edge and never show a mismatched digit/anode pair.
- Input values exceeding 10^DIGITS-1 are legal; they produce ovf=1. The low-digit contents of the display register are then don't-care but must be deterministic.

Test Plan (REFRESH_DIV=4, WIDTH=14, DIGITS=4 unless stated):
- reset for 2 cycles → an=4'hF, seg=7'h7F, busy=0, ovf=0. Then the scan cycles an 1110→1101→1011→0111, each held 4 clocks, with seg=40 (digit 0) on each digit when blank_lz=0.
- bin=1234, load pulse → busy high exactly 15 cycles. Then the scan shows seg 19 on an[0], 30 on an[1], 24 on an[2], 79 on an[3]; ovf=0.
- bin=9999 → all digits seg=10, ovf=0. Then bin=10000 → every digit seg=3F, ovf=1. Then bin=7 with blank_lz=1 → an[0] seg=78, digits 1-3 seg=7F, ovf=0.
- bin=0, blank_lz=1 → only digit 0 shows 40 and the others show 7F. bin=1005, blank_lz=1 → digits show 12, 40, 40, 79 (interior zeros not blanked).
- load bin=42, then load bin=99 on cycle 3 while busy → result 42. Assert reset on cycle 8 of a conversion of 5555 → display returns to zeros; no 5555 appears and busy=0.
- WIDTH=20, DIGITS=6: bin=999999 → six 9s (seg 10), busy high 21 cycles. bin=1000000 → six dashes, ovf=1.
